// File: rtl/fsm_code_pkg.sv
// Shared types and helpers for the encoded-state monitor.
package fsm_code_pkg;

    // Monitor FSM states; the unused encoding 2'b11 is treated as fail-secure.
    typedef enum logic [1:0] {
        MON_IDLE   = 2'd0,
        MON_TRACK  = 2'd1,
        MON_LOCKED = 2'd2
    } mon_state_e;

    // Position of the "well-formed" marker bit in the encoded state word.
    localparam int unsigned VALID_BIT = 2;

    // Legal moves of the observed state register from p to s.
    function automatic logic is_legal_transition(input logic [1:0] p, input logic [1:0] s);
        logic legal;
        legal = (s == p) ||
                (s == 2'd0) ||
                (p == 2'd0) ||
                ((p == 2'd3) && (s == 2'd2)) ||
                ((p == 2'd2) && (s == 2'd1));
        return legal;
    endfunction

endpackage

// File: rtl/fsm_code_err_counter.sv
// Saturating violation counter with synchronous clear and lock-threshold compare.
module fsm_code_err_counter #(
    parameter int unsigned ERR_CNT_W      = 4,
    parameter int unsigned LOCK_THRESHOLD = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc_i,
    input  logic                 clr_i,
    output logic [ERR_CNT_W-1:0] count_o,
    output logic                 hit_o
);

    localparam logic [ERR_CNT_W-1:0] CntMax = '1;
    localparam logic [ERR_CNT_W-1:0] Thresh = ERR_CNT_W'(LOCK_THRESHOLD);

    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
    logic [ERR_CNT_W-1:0] cnt_inc;

    // Next count; hit_o reports whether an increment this cycle would reach the threshold.
    always_comb begin
        cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + ERR_CNT_W'(1);
        hit_o   = (cnt_inc >= Thresh);
        cnt_d   = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_inc;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/fsm_code_monitor.sv
// Receiver-side checker for the {1'b1, state[1:0]} encoded state word: rejects malformed
// words and illegal transitions, counts violations and locks the consumer path.
module fsm_code_monitor
    import fsm_code_pkg::*;
#(
    parameter int unsigned ERR_CNT_W      = 4,
    parameter int unsigned LOCK_THRESHOLD = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [2:0]           in_code,
    input  logic                 clear_lock,
    output logic [1:0]           state_out,
    output logic                 state_valid,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 locked
);

    mon_state_e st_q, st_d;
    logic [1:0] state_out_q, state_out_d;
    logic       state_valid_q, state_valid_d;
    logic       err_pulse_q, err_pulse_d;
    logic       locked_q, locked_d;

    logic       err;
    logic       err_inc;
    logic       cnt_clr;
    logic       cnt_hit;
    logic       code_ok;
    logic [1:0] code_s;

    assign code_s  = in_code[1:0];
    assign code_ok = in_code[VALID_BIT];

    fsm_code_err_counter #(
        .ERR_CNT_W      (ERR_CNT_W),
        .LOCK_THRESHOLD (LOCK_THRESHOLD)
    ) u_err_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (err_inc),
        .clr_i   (cnt_clr),
        .count_o (err_count),
        .hit_o   (cnt_hit)
    );

    // Next-state and registered-output logic.
    always_comb begin
        st_d          = st_q;
        state_out_d   = state_out_q;
        state_valid_d = state_valid_q;
        err_pulse_d   = 1'b0;
        locked_d      = locked_q;
        err           = 1'b0;
        err_inc       = 1'b0;
        cnt_clr       = 1'b0;

        if (clear_lock) begin
            // Clear wins over a same-cycle sample; the sample is dropped.
            cnt_clr = 1'b1;
            if (st_q == MON_LOCKED) begin
                st_d          = MON_IDLE;
                locked_d      = 1'b0;
                state_out_d   = 2'd0;
                state_valid_d = 1'b0;
            end
        end else begin
            case (st_q)
                MON_IDLE: begin
                    if (in_valid) begin
                        if (!code_ok) begin
                            err = 1'b1;
                        end else begin
                            // First reference sample: nothing to check against yet.
                            state_out_d   = code_s;
                            state_valid_d = 1'b1;
                            st_d          = MON_TRACK;
                        end
                    end
                end
                MON_TRACK: begin
                    if (in_valid) begin
                        if (!code_ok || !is_legal_transition(state_out_q, code_s)) begin
                            err = 1'b1;
                        end else begin
                            state_out_d = code_s;
                        end
                    end
                end
                MON_LOCKED: begin
                    // Samples ignored until clear_lock.
                    state_out_d   = 2'd0;
                    state_valid_d = 1'b0;
                    locked_d      = 1'b1;
                end
                default: begin
                    // Corrupted state register: fail secure.
                    st_d          = MON_LOCKED;
                    state_out_d   = 2'd0;
                    state_valid_d = 1'b0;
                    locked_d      = 1'b1;
                end
            endcase

            if (err) begin
                err_inc     = 1'b1;
                err_pulse_d = 1'b1;
                if (cnt_hit) begin
                    st_d          = MON_LOCKED;
                    state_out_d   = 2'd0;
                    state_valid_d = 1'b0;
                    locked_d      = 1'b1;
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q          <= MON_IDLE;
            state_out_q   <= 2'd0;
            state_valid_q <= 1'b0;
            err_pulse_q   <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            st_q          <= st_d;
            state_out_q   <= state_out_d;
            state_valid_q <= state_valid_d;
            err_pulse_q   <= err_pulse_d;
            locked_q      <= locked_d;
        end
    end

    assign state_out   = state_out_q;
    assign state_valid = state_valid_q;
    assign err_pulse   = err_pulse_q;
    assign locked      = locked_q;

endmodule

// File: tb/tb_fsm_code_monitor.sv
// Directed scoreboard bench for fsm_code_monitor.
module tb_fsm_code_monitor;

    localparam int unsigned ERR_CNT_W      = 4;
    localparam int unsigned LOCK_THRESHOLD = 3;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic [2:0]           in_code;
    logic                 clear_lock;
    logic [1:0]           state_out;
    logic                 state_valid;
    logic                 err_pulse;
    logic [ERR_CNT_W-1:0] err_count;
    logic                 locked;

    int n_asserts = 0;
    int n_fail    = 0;

    // Expected {state_out, state_valid, err_pulse, err_count, locked}.
    logic [8:0] exp_q[$];

    fsm_code_monitor #(
        .ERR_CNT_W      (ERR_CNT_W),
        .LOCK_THRESHOLD (LOCK_THRESHOLD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_code     (in_code),
        .clear_lock  (clear_lock),
        .state_out   (state_out),
        .state_valid (state_valid),
        .err_pulse   (err_pulse),
        .err_count   (err_count),
        .locked      (locked)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] exp_vec(input logic [1:0] so, input logic sv, input logic ep,
                                           input logic [3:0] ec, input logic lk);
        return {so, sv, ep, ec, lk};
    endfunction

    task automatic check(input string tag);
        logic [8:0] obs;
        logic [8:0] e;
        obs = {state_out, state_valid, err_pulse, err_count, locked};
        n_asserts++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s: scoreboard empty, observed %b", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s: observed so/sv/ep/ec/lk=%b required %b", tag, obs, e);
            end
        end
    endtask

    // Drive one cycle of stimulus, queue its expected response, sample after the edge.
    task automatic step(input logic v, input logic [2:0] code, input logic clr,
                        input logic [8:0] e, input string tag);
        in_valid   = v;
        in_code    = code;
        clear_lock = clr;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check(tag);
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_code    = 3'b000;
        clear_lock = 1'b0;
        #12;
        exp_q.push_back(exp_vec(2'd0, 1'b0, 1'b0, 4'd0, 1'b0));
        check("reset");
        rst_n = 1'b1;

        // Legal descending walk, first sample accepted unchecked.
        step(1'b1, 3'b111, 1'b0, exp_vec(2'd3, 1'b1, 1'b0, 4'd0, 1'b0), "walk_3");
        step(1'b1, 3'b110, 1'b0, exp_vec(2'd2, 1'b1, 1'b0, 4'd0, 1'b0), "walk_2");
        step(1'b1, 3'b101, 1'b0, exp_vec(2'd1, 1'b1, 1'b0, 4'd0, 1'b0), "walk_1");
        step(1'b1, 3'b100, 1'b0, exp_vec(2'd0, 1'b1, 1'b0, 4'd0, 1'b0), "walk_0");
        step(1'b1, 3'b101, 1'b0, exp_vec(2'd1, 1'b1, 1'b0, 4'd0, 1'b0), "to_1");

        // Illegal 1->3: pulse, hold state, count.
        step(1'b1, 3'b111, 1'b0, exp_vec(2'd1, 1'b1, 1'b1, 4'd1, 1'b0), "trans_1_3");
        step(1'b0, 3'b111, 1'b0, exp_vec(2'd1, 1'b1, 1'b0, 4'd1, 1'b0), "pulse_drop");
        // Clear outside LOCKED: counter only.
        step(1'b0, 3'b000, 1'b1, exp_vec(2'd1, 1'b1, 1'b0, 4'd0, 1'b0), "clr_track");

        // Bad encodings up to the lock threshold.
        step(1'b1, 3'b011, 1'b0, exp_vec(2'd1, 1'b1, 1'b1, 4'd1, 1'b0), "bad_1");
        step(1'b1, 3'b011, 1'b0, exp_vec(2'd1, 1'b1, 1'b1, 4'd2, 1'b0), "bad_2");
        step(1'b1, 3'b011, 1'b0, exp_vec(2'd0, 1'b0, 1'b1, 4'd3, 1'b1), "bad_3_lock");
        step(1'b1, 3'b100, 1'b0, exp_vec(2'd0, 1'b0, 1'b0, 4'd3, 1'b1), "locked_ignore");
        step(1'b0, 3'b000, 1'b1, exp_vec(2'd0, 1'b0, 1'b0, 4'd0, 1'b0), "clr_locked");
        step(1'b1, 3'b110, 1'b0, exp_vec(2'd2, 1'b1, 1'b0, 4'd0, 1'b0), "idle_accept");

        // clear_lock beats a same-cycle bad sample.
        step(1'b1, 3'b010, 1'b0, exp_vec(2'd2, 1'b1, 1'b1, 4'd1, 1'b0), "bad_a");
        step(1'b1, 3'b010, 1'b0, exp_vec(2'd2, 1'b1, 1'b1, 4'd2, 1'b0), "bad_b");
        step(1'b1, 3'b010, 1'b1, exp_vec(2'd2, 1'b1, 1'b0, 4'd0, 1'b0), "clr_priority");

        // Lock again, then asynchronous reset mid-cycle.
        step(1'b1, 3'b010, 1'b0, exp_vec(2'd2, 1'b1, 1'b1, 4'd1, 1'b0), "relock_1");
        step(1'b1, 3'b010, 1'b0, exp_vec(2'd2, 1'b1, 1'b1, 4'd2, 1'b0), "relock_2");
        step(1'b1, 3'b010, 1'b0, exp_vec(2'd0, 1'b0, 1'b1, 4'd3, 1'b1), "relock_3");
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(exp_vec(2'd0, 1'b0, 1'b0, 4'd0, 1'b0));
        check("async_reset");
        @(negedge clk);
        rst_n = 1'b1;

        // After reset: IDLE takes first sample, then TRACK checks transitions.
        step(1'b0, 3'b000, 1'b0, exp_vec(2'd0, 1'b0, 1'b0, 4'd0, 1'b0), "post_reset");
        step(1'b1, 3'b101, 1'b0, exp_vec(2'd1, 1'b1, 1'b0, 4'd0, 1'b0), "first_1");
        step(1'b1, 3'b111, 1'b0, exp_vec(2'd1, 1'b1, 1'b1, 4'd1, 1'b0), "trans_1_3b");
        step(1'b1, 3'b101, 1'b0, exp_vec(2'd1, 1'b1, 1'b0, 4'd1, 1'b0), "same_1");
        step(1'b1, 3'b100, 1'b0, exp_vec(2'd0, 1'b1, 1'b0, 4'd1, 1'b0), "to_0");
        step(1'b1, 3'b111, 1'b0, exp_vec(2'd3, 1'b1, 1'b0, 4'd1, 1'b0), "trans_0_3");
        step(1'b1, 3'b101, 1'b0, exp_vec(2'd3, 1'b1, 1'b1, 4'd2, 1'b0), "trans_3_1");
        step(1'b1, 3'b110, 1'b0, exp_vec(2'd2, 1'b1, 1'b0, 4'd2, 1'b0), "trans_3_2");
        step(1'b1, 3'b111, 1'b0, exp_vec(2'd0, 1'b0, 1'b1, 4'd3, 1'b1), "trans_2_3_lock");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
